// File: rtl/execute_multicycle.sv
// rtl/execute_multicycle.sv - venus execute stage: single-cycle ADD/SUB/CMP, iterative MUL/DIV/MOD
module execute_multicycle #(
    parameter int W_OPR    = 32,
    parameter int W_IMM    = 16,
    parameter int W_OPC    = 7,
    parameter int W_RD     = 5,
    parameter int MUL_STEP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic [W_OPC-1:0] opecode_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic             immf_i,
    input  logic             immsign_i,
    input  logic [W_IMM-1:0] imm_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic [3:0]       flags_o
);

    localparam int W_CNT = $clog2(W_OPR + 1);
    localparam logic [W_CNT-1:0] MUL_ITER = W_CNT'(W_OPR / MUL_STEP);
    localparam logic [W_CNT-1:0] DIV_ITER = W_CNT'(W_OPR);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_CMP = 5'd4;
    localparam logic [4:0] OP_MOD = 5'd6;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state, state_next;

    logic [W_CNT-1:0] cnt;
    logic [W_OPR-1:0] acc;
    logic [W_OPR-1:0] opa;
    logic [W_OPR-1:0] opb;
    logic             sel_acc;
    logic             hold_wb;
    logic [W_RD-1:0]  hold_rd;

    logic             v_q;
    logic             wb_q;
    logic [W_OPR-1:0] res_q;
    logic [W_RD-1:0]  rd_q;
    logic [3:0]       flags_q;

    // Opcodes with any upper bit set decode as NOP.
    logic       opc_ok;
    logic [4:0] op;
    logic       is_add, is_sub, is_cmp, is_mul, is_div, is_mod;
    logic       multi_req;

    assign opc_ok = ((opecode_i >> 5) == '0);
    assign op     = opecode_i[4:0];
    assign is_add = opc_ok && (op == OP_ADD);
    assign is_sub = opc_ok && (op == OP_SUB);
    assign is_cmp = opc_ok && (op == OP_CMP);
    assign is_mul = opc_ok && (op == OP_MUL);
    assign is_div = opc_ok && (op == OP_DIV);
    assign is_mod = opc_ok && (op == OP_MOD);
    assign multi_req = (state == S_IDLE) && v_i && (is_mul || is_div || is_mod);

    logic [W_OPR-1:0] imm_ext;
    logic [W_OPR-1:0] b;
    logic [W_OPR:0]   add_full;
    logic [W_OPR:0]   sub_full;

    assign imm_ext  = immsign_i ? W_OPR'($signed(imm_i)) : W_OPR'(imm_i);
    assign b        = immf_i ? imm_ext : opr1_i;
    assign add_full = {1'b0, opr0_i} + {1'b0, b};
    assign sub_full = {1'b0, opr0_i} - {1'b0, b};

    logic [W_OPR-1:0] alu_out;
    logic [W_OPR-1:0] flag_src;
    logic             flag_c, flag_v;
    logic             flag_op;

    always_comb begin
        alu_out  = '0;
        flag_src = sub_full[W_OPR-1:0];
        flag_c   = sub_full[W_OPR];
        flag_v   = (opr0_i[W_OPR-1] != b[W_OPR-1]) &&
                   (sub_full[W_OPR-1] != opr0_i[W_OPR-1]);
        flag_op  = is_add || is_sub || is_cmp;
        if (is_add) begin
            alu_out  = add_full[W_OPR-1:0];
            flag_src = add_full[W_OPR-1:0];
            flag_c   = add_full[W_OPR];
            flag_v   = (opr0_i[W_OPR-1] == b[W_OPR-1]) &&
                       (add_full[W_OPR-1] != opr0_i[W_OPR-1]);
        end else if (is_sub) begin
            alu_out = sub_full[W_OPR-1:0];
        end
    end

    logic [W_OPR-1:0] partial;
    logic [W_OPR:0]   rem_shift;
    logic [W_OPR-1:0] rem_diff;
    logic             rem_ge;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (opa[j]) partial = partial + (opb << j);
        end
    end

    // Divide: opa shifts the dividend out of its MSB while quotient bits enter at its LSB.
    assign rem_shift = {acc, opa[W_OPR-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opb});
    assign rem_diff  = rem_shift[W_OPR-1:0] - opb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (multi_req) state_next = is_mul ? S_MUL : S_DIV;
            S_MUL:   if (cnt == W_CNT'(1)) state_next = S_DONE;
            S_DIV:   if (cnt == W_CNT'(1)) state_next = S_DONE;
            S_DONE:  if (!stall_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall_o = stall_i;
        case (state)
            S_IDLE:  if (multi_req) stall_o = 1'b1;
            S_MUL:   stall_o = 1'b1;
            S_DIV:   stall_o = 1'b1;
            default: stall_o = stall_i;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            sel_acc <= 1'b0;
            hold_wb <= 1'b0;
            hold_rd <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (multi_req) begin
                        cnt     <= is_mul ? MUL_ITER : DIV_ITER;
                        acc     <= '0;
                        opa     <= is_mul ? b : opr0_i;
                        opb     <= is_mul ? opr0_i : b;
                        sel_acc <= is_mul || is_mod;
                        hold_wb <= wb_i;
                        hold_rd <= wb_r_i;
                    end
                end
                S_MUL: begin
                    acc <= acc + partial;
                    opb <= opb << MUL_STEP;
                    opa <= opa >> MUL_STEP;
                    cnt <= cnt - W_CNT'(1);
                end
                S_DIV: begin
                    acc <= rem_ge ? rem_diff : rem_shift[W_OPR-1:0];
                    opa <= {opa[W_OPR-2:0], rem_ge};
                    cnt <= cnt - W_CNT'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q     <= 1'b0;
            wb_q    <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            flags_q <= '0;
        end else begin
            if ((state == S_IDLE) && v_i && flag_op && !stall_i)
                flags_q <= {flag_v, flag_src[W_OPR-1], (flag_src == '0), flag_c};
            if (multi_req && (is_div || is_mod) && (b == '0))
                flags_q[3] <= 1'b1;
            if (!stall_i) begin
                case (state)
                    S_IDLE: begin
                        if (multi_req) begin
                            v_q <= 1'b0;
                        end else begin
                            v_q   <= v_i;
                            res_q <= alu_out;
                            wb_q  <= wb_i;
                            rd_q  <= wb_r_i;
                        end
                    end
                    S_DONE: begin
                        v_q   <= 1'b1;
                        res_q <= sel_acc ? acc : opa;
                        wb_q  <= hold_wb;
                        rd_q  <= hold_rd;
                    end
                    default: v_q <= 1'b0;
                endcase
            end
        end
    end

    assign v_o      = v_q;
    assign result_o = res_q;
    assign wb_o     = wb_q & v_q;
    assign wb_r_o   = rd_q;
    assign flags_o  = flags_q;

endmodule

// File: tb/tb_execute_multicycle.sv
// tb/tb_execute_multicycle.sv - directed-vector bench for execute_multicycle
module tb_execute_multicycle;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        v_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        stall_o;
    logic [6:0]  opecode_i = '0;
    logic [31:0] opr0_i = '0;
    logic [31:0] opr1_i = '0;
    logic        immf_i = 1'b0;
    logic        immsign_i = 1'b0;
    logic [15:0] imm_i = '0;
    logic        wb_i = 1'b0;
    logic [4:0]  wb_r_i = '0;
    logic        v_o;
    logic [31:0] result_o;
    logic        wb_o;
    logic [4:0]  wb_r_o;
    logic [3:0]  flags_o;

    int n_checks = 0;
    int n_errors = 0;

    execute_multicycle dut (
        .clk       (clk),
        .reset     (reset),
        .v_i       (v_i),
        .stall_i   (stall_i),
        .stall_o   (stall_o),
        .opecode_i (opecode_i),
        .opr0_i    (opr0_i),
        .opr1_i    (opr1_i),
        .immf_i    (immf_i),
        .immsign_i (immsign_i),
        .imm_i     (imm_i),
        .wb_i      (wb_i),
        .wb_r_i    (wb_r_i),
        .v_o       (v_o),
        .result_o  (result_o),
        .wb_o      (wb_o),
        .wb_r_o    (wb_r_o),
        .flags_o   (flags_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Holds the instruction until an edge with stall_o low, then waits for v_o.
    task automatic run_op(input string tag, input logic [6:0] op,
                          input logic [31:0] a, input logic [31:0] bb,
                          input logic immf, input logic immsign, input logic [15:0] imm,
                          input logic wb, input logic [4:0] rd,
                          input int sf, input int st,
                          input int exp_lat, input int exp_stalls,
                          input logic [31:0] exp_res, input logic [3:0] exp_flags);
        int   edges;
        int   stalls;
        logic got;
        logic s;
        opecode_i = op; opr0_i = a; opr1_i = bb;
        immf_i = immf; immsign_i = immsign; imm_i = imm;
        wb_i = wb; wb_r_i = rd; v_i = 1'b1;
        edges = 0; stalls = 0; got = 1'b0;
        while (!got && edges < 100) begin
            stall_i = (edges >= sf) && (edges <= st);
            #1;
            s = stall_o;
            if (s) stalls++;
            @(posedge clk); #1;
            edges++;
            if (!s) v_i = 1'b0;
            if (v_o) got = 1'b1;
        end
        v_i = 1'b0;
        stall_i = 1'b0;
        check($sformatf("%s_lat", tag), edges, exp_lat);
        check($sformatf("%s_stall", tag), stalls, exp_stalls);
        check($sformatf("%s_res", tag), result_o, exp_res);
        check($sformatf("%s_flags", tag), {28'd0, flags_o}, {28'd0, exp_flags});
        check($sformatf("%s_wb", tag), {31'd0, wb_o}, {31'd0, wb});
        check($sformatf("%s_rd", tag), {27'd0, wb_r_o}, {27'd0, rd});
        @(posedge clk); #1;
        check($sformatf("%s_once", tag), {31'd0, v_o}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_v", {31'd0, v_o}, 32'd0);
        check("rst_res", result_o, 32'd0);
        check("rst_flags", {28'd0, flags_o}, 32'd0);
        reset = 1'b0;
        #1;
        check("rst_wb", {31'd0, wb_o}, 32'd0);
        check("rst_rd", {27'd0, wb_r_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);

        //      tag        op  opr0          opr1          immf immsign imm      wb  rd    sf  st  lat stl result        flags
        run_op("add_ovf",  0, 32'h7FFFFFFF, 32'h00000001, 0,   0,      16'h0,   1, 5'd1, -1, -1, 1,  0, 32'h80000000, 4'b1100);
        run_op("cmp_imm",  4, 32'h00000005, 32'h00000000, 1,   1,      16'hFFFF, 0, 5'd2, -1, -1, 1,  0, 32'h00000000, 4'b0001);
        run_op("add_zext", 0, 32'h00000001, 32'h00000000, 1,   0,      16'hFFFF, 1, 5'd3, -1, -1, 1,  0, 32'h00010000, 4'b0000);
        run_op("sub_neg",  1, 32'h00000003, 32'h00000005, 0,   0,      16'h0,   1, 5'd4, -1, -1, 1,  0, 32'hFFFFFFFE, 4'b0101);
        run_op("sub_zero", 1, 32'h00000007, 32'h00000007, 0,   0,      16'h0,   1, 5'd5, -1, -1, 1,  0, 32'h00000000, 4'b0010);
        run_op("nop",      5, 32'h00000003, 32'h00000004, 0,   0,      16'h0,   1, 5'd9, -1, -1, 1,  0, 32'h00000000, 4'b0010);
        run_op("mul",      2, 32'h12345678, 32'h00000010, 0,   0,      16'h0,   1, 5'd6, -1, -1, 18, 17, 32'h23456780, 4'b0010);
        run_op("mul_ones", 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,   0,      16'h0,   1, 5'd7, -1, -1, 18, 17, 32'h00000001, 4'b0010);
        run_op("mul_odd",  2, 32'hDEADBEEF, 32'h00000003, 0,   0,      16'h0,   1, 5'd8, -1, -1, 18, 17, 32'h9C093CCD, 4'b0010);
        run_op("div",      3, 32'd100,      32'd7,        0,   0,      16'h0,   1, 5'd10, -1, -1, 34, 33, 32'd14,      4'b0010);
        run_op("mod",      6, 32'd100,      32'd7,        0,   0,      16'h0,   1, 5'd11, -1, -1, 34, 33, 32'd2,       4'b0010);
        run_op("div_z",    3, 32'd5,        32'd0,        0,   0,      16'h0,   1, 5'd12, -1, -1, 34, 33, 32'hFFFFFFFF, 4'b1010);
        run_op("mod_z",    6, 32'd5,        32'd0,        0,   0,      16'h0,   1, 5'd13, -1, -1, 34, 33, 32'd5,       4'b1010);
        run_op("mul_stl",  2, 32'h12345678, 32'h00000010, 0,   0,      16'h0,   1, 5'd14, 10, 30, 32, 31, 32'h23456780, 4'b1010);

        opecode_i = 7'd3; opr0_i = 32'd100; opr1_i = 32'd7; immf_i = 1'b0;
        wb_i = 1'b1; wb_r_i = 5'd15; v_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        v_i = 1'b0; stall_i = 1'b1; reset = 1'b1;
        #1;
        check("mid_rst_v", {31'd0, v_o}, 32'd0);
        check("mid_rst_stall_hi", {31'd0, stall_o}, 32'd1);
        check("mid_rst_flags", {28'd0, flags_o}, 32'd0);
        check("mid_rst_res", result_o, 32'd0);
        stall_i = 1'b0;
        #1;
        check("mid_rst_stall_lo", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_op("add_post", 0, 32'd2, 32'd3, 0, 0, 16'h0, 1, 5'd16, -1, -1, 1, 0, 32'd5, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
